video_mixer_collision: RTL and testbench

Downstream pixel stage consuming the sync generator's timing and the per-pixel graphics flags of the ball, playfield and grid generators. It prioritises and colours the layers and blanks outside the display area. It delays sync by the same pipeline depth so rgb and sync stay aligned. It also detects ball/playfield and ball/border collisions per frame and reports them, with the first-hit coordinates, at each vsync rising edge for game logic (bounce/score).

---
 rtl/video_pkg.sv | 17 +
 rtl/pixel_delay_line.sv | 26 ++
 rtl/video_mixer_collision.sv | 149 ++++++++++++++
 tb/tb_video_mixer_collision.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and FSM encoding for the video mixer / collision block.
package video_pkg;

  localparam logic [2:0] BLACK    = 3'b000;
  localparam logic [2:0] BALL_RGB = 3'b111;
  localparam logic [2:0] PF_RGB   = 3'b010;
  localparam logic [2:0] GRID_RGB = 3'b100;

  localparam logic [8:0] H_MAX = 9'd255;
  localparam logic [8:0] V_MAX = 9'd239;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register keeping pixel colour and sync bits aligned.
module pixel_delay_line #(
  parameter int DATA_W = 6,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] pipe_p [STAGES];

  // Stage boundary: entry register, then pure delay stages
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign q = pipe_p[STAGES-1];

endmodule

// File: rtl/video_mixer_collision.sv
// Layer priority mixer with aligned sync delay and per-frame ball collision reporting.
module video_mixer_collision
  import video_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       ball_gfx,
  input  logic       pf_gfx,
  input  logic       grid_gfx,
  input  logic       coll_ack,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_done,
  output logic       coll_pf,
  output logic       coll_border,
  output logic [8:0] hit_hpos,
  output logic [8:0] hit_vpos,
  output logic [7:0] frame_count
);

  logic [2:0] colour;
  logic [2:0] rgb_d;
  logic       disp_d;

  always_comb begin
    colour = BLACK;
    if (!display_on)   colour = BLACK;
    else if (ball_gfx) colour = BALL_RGB;
    else if (pf_gfx)   colour = PF_RGB;
    else if (grid_gfx) colour = GRID_RGB;
  end

  pixel_delay_line #(
    .DATA_W (6),
    .STAGES (PIPE_STAGES)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({display_on, hsync_in, vsync_in, colour}),
    .q     ({disp_d, hsync, vsync, rgb_d})
  );

  assign rgb = rgb_d & {3{disp_d}};

  logic   hit_pf, hit_bd, vs_rise, vsync_prev;
  state_t state_q, state_d;
  logic   acc_pf, acc_bd, acc_pf_d, acc_bd_d;
  logic [8:0] first_h, first_v, first_h_d, first_v_d;
  logic [8:0] hit_hpos_d, hit_vpos_d;
  logic [7:0] frame_count_d;
  logic   coll_pf_d, coll_border_d, frame_done_d;

  assign hit_pf  = display_on & ball_gfx & pf_gfx;
  assign hit_bd  = display_on & ball_gfx &
                   ((hpos == 9'd0) | (hpos == H_MAX) | (vpos == 9'd0) | (vpos == V_MAX));
  assign vs_rise = vsync_in & ~vsync_prev;

  always_comb begin
    state_d       = state_q;
    acc_pf_d      = acc_pf;
    acc_bd_d      = acc_bd;
    first_h_d     = first_h;
    first_v_d     = first_v;
    hit_hpos_d    = hit_hpos;
    hit_vpos_d    = hit_vpos;
    frame_count_d = frame_count;
    frame_done_d  = 1'b0;
    // Ack clears first so a coincident report leaves only the new frame's result
    coll_pf_d     = coll_ack ? 1'b0 : coll_pf;
    coll_border_d = coll_ack ? 1'b0 : coll_border;
    case (state_q)
      WAIT_SYNC: begin
        if (vs_rise) begin
          acc_pf_d  = 1'b0;
          acc_bd_d  = 1'b0;
          first_h_d = '0;
          first_v_d = '0;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          frame_done_d  = 1'b1;
          coll_pf_d     = coll_pf_d | acc_pf | hit_pf;
          coll_border_d = coll_border_d | acc_bd | hit_bd;
          if (acc_pf) begin
            hit_hpos_d = first_h;
            hit_vpos_d = first_v;
          end else if (hit_pf) begin
            hit_hpos_d = hpos;
            hit_vpos_d = vpos;
          end
          frame_count_d = frame_count + 8'd1;
          acc_pf_d      = 1'b0;
          acc_bd_d      = 1'b0;
          first_h_d     = '0;
          first_v_d     = '0;
        end else begin
          acc_pf_d = acc_pf | hit_pf;
          acc_bd_d = acc_bd | hit_bd;
          if (hit_pf && !acc_pf) begin
            first_h_d = hpos;
            first_v_d = vpos;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      vsync_prev  <= 1'b0;
      acc_pf      <= 1'b0;
      acc_bd      <= 1'b0;
      first_h     <= '0;
      first_v     <= '0;
      hit_hpos    <= '0;
      hit_vpos    <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      coll_pf     <= 1'b0;
      coll_border <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_prev  <= vsync_in;
      acc_pf      <= acc_pf_d;
      acc_bd      <= acc_bd_d;
      first_h     <= first_h_d;
      first_v     <= first_v_d;
      hit_hpos    <= hit_hpos_d;
      hit_vpos    <= hit_vpos_d;
      frame_count <= frame_count_d;
      frame_done  <= frame_done_d;
      coll_pf     <= coll_pf_d;
      coll_border <= coll_border_d;
    end
  end

endmodule

// File: tb/tb_video_mixer_collision.sv
// Directed bench for the video mixer: pixel priority/latency and frame collision reporting.
module tb_video_mixer_collision;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, ball_gfx, pf_gfx, grid_gfx, coll_ack;
  logic [2:0] rgb;
  logic       hsync, vsync, frame_done, coll_pf, coll_border;
  logic [8:0] hit_hpos, hit_vpos;
  logic [7:0] frame_count;

  int errors = 0;
  int checks = 0;

  video_mixer_collision #(.PIPE_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .ball_gfx    (ball_gfx),
    .pf_gfx      (pf_gfx),
    .grid_gfx    (grid_gfx),
    .coll_ack    (coll_ack),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_done  (frame_done),
    .coll_pf     (coll_pf),
    .coll_border (coll_border),
    .hit_hpos    (hit_hpos),
    .hit_vpos    (hit_vpos),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hpos = 9'd0; vpos = 9'd0;
    display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    ball_gfx = 1'b0; pf_gfx = 1'b0; grid_gfx = 1'b0; coll_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hpos = 9'd0; vpos = 9'd0;
    display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    ball_gfx = 1'b1; pf_gfx = 1'b1; grid_gfx = 1'b1; coll_ack = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (rgb !== 3'b000 || hsync !== 1'b0 || vsync !== 1'b0) begin
      $display("FAIL reset_pixel rgb=%b hs=%b vs=%b expected 000/0/0", rgb, hsync, vsync);
      errors++;
    end
    checks++;
    if (frame_done !== 1'b0 || coll_pf !== 1'b0 || coll_border !== 1'b0 ||
        frame_count !== 8'd0 || hit_hpos !== 9'd0 || hit_vpos !== 9'd0) begin
      $display("FAIL reset_status fd=%b cp=%b cb=%b fc=%0d h=%0d v=%0d expected all 0",
               frame_done, coll_pf, coll_border, frame_count, hit_hpos, hit_vpos);
      errors++;
    end
    idle_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pixel_path();
    // A: ball+pf visible with hsync pulse -> 111
    display_on = 1'b1; ball_gfx = 1'b1; pf_gfx = 1'b1; hsync_in = 1'b1;
    tick();
    // B: same pixel blanked -> 000
    display_on = 1'b0; hsync_in = 1'b0;
    checks++;
    if (rgb !== 3'b000 || hsync !== 1'b0) begin
      $display("FAIL latency_early rgb=%b hs=%b expected 000/0", rgb, hsync);
      errors++;
    end
    tick();
    checks++;
    if (rgb !== 3'b111 || hsync !== 1'b1) begin
      $display("FAIL ball_pixel rgb=%b hs=%b expected 111/1", rgb, hsync);
      errors++;
    end
    // C: grid only -> 100
    display_on = 1'b1; ball_gfx = 1'b0; pf_gfx = 1'b0; grid_gfx = 1'b1;
    tick();
    checks++;
    if (rgb !== 3'b000 || hsync !== 1'b0) begin
      $display("FAIL blanked_pixel rgb=%b hs=%b expected 000/0", rgb, hsync);
      errors++;
    end
    // D: pf over grid -> 010
    pf_gfx = 1'b1;
    tick();
    checks++;
    if (rgb !== 3'b100) begin
      $display("FAIL grid_pixel rgb=%b expected 100", rgb);
      errors++;
    end
    idle_inputs();
    tick();
    checks++;
    if (rgb !== 3'b010) begin
      $display("FAIL pf_pixel rgb=%b expected 010", rgb);
      errors++;
    end
    tick();
  endtask

  task automatic test_collision_report();
    vsync_in = 1'b1;
    tick();
    checks++;
    if (frame_done !== 1'b0 || frame_count !== 8'd0) begin
      $display("FAIL first_vsync fd=%b fc=%0d expected 0/0", frame_done, frame_count);
      errors++;
    end
    vsync_in = 1'b0;
    tick();
    display_on = 1'b1; ball_gfx = 1'b1; pf_gfx = 1'b1; hpos = 9'd100; vpos = 9'd50;
    tick();
    hpos = 9'd120; vpos = 9'd60;
    tick();
    idle_inputs();
    tick();
    vsync_in = 1'b1;
    tick();
    checks++;
    if (frame_done !== 1'b1 || coll_pf !== 1'b1 || coll_border !== 1'b0 ||
        hit_hpos !== 9'd100 || hit_vpos !== 9'd50 || frame_count !== 8'd1) begin
      $display("FAIL pf_report fd=%b cp=%b cb=%b h=%0d v=%0d fc=%0d expected 1/1/0/100/50/1",
               frame_done, coll_pf, coll_border, hit_hpos, hit_vpos, frame_count);
      errors++;
    end
    vsync_in = 1'b0;
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      $display("FAIL frame_done_pulse fd=%b expected 0", frame_done);
      errors++;
    end
  endtask

  task automatic test_border();
    coll_ack = 1'b1;
    tick();
    coll_ack = 1'b0;
    checks++;
    if (coll_pf !== 1'b0) begin
      $display("FAIL ack_pf cp=%b expected 0", coll_pf);
      errors++;
    end
    display_on = 1'b1; ball_gfx = 1'b1; hpos = 9'd255; vpos = 9'd100;
    tick();
    idle_inputs();
    vsync_in = 1'b1;
    tick();
    checks++;
    if (frame_done !== 1'b1 || coll_border !== 1'b1 || coll_pf !== 1'b0 ||
        hit_hpos !== 9'd100 || hit_vpos !== 9'd50 || frame_count !== 8'd2) begin
      $display("FAIL border_report fd=%b cb=%b cp=%b h=%0d v=%0d fc=%0d expected 1/1/0/100/50/2",
               frame_done, coll_border, coll_pf, hit_hpos, hit_vpos, frame_count);
      errors++;
    end
    vsync_in = 1'b0;
    coll_ack = 1'b1;
    tick();
    coll_ack = 1'b0;
    checks++;
    if (coll_border !== 1'b0 || coll_pf !== 1'b0) begin
      $display("FAIL ack_border cb=%b cp=%b expected 0/0", coll_border, coll_pf);
      errors++;
    end
  endtask

  task automatic test_ack_with_report();
    display_on = 1'b1; ball_gfx = 1'b1; pf_gfx = 1'b1; hpos = 9'd10; vpos = 9'd20;
    tick();
    idle_inputs();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    checks++;
    if (coll_pf !== 1'b1 || hit_hpos !== 9'd10 || hit_vpos !== 9'd20 || frame_count !== 8'd3) begin
      $display("FAIL setup_pf cp=%b h=%0d v=%0d fc=%0d expected 1/10/20/3",
               coll_pf, hit_hpos, hit_vpos, frame_count);
      errors++;
    end
    tick();
    // Empty frame; ack lands on the report cycle
    vsync_in = 1'b1; coll_ack = 1'b1;
    tick();
    vsync_in = 1'b0; coll_ack = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || coll_pf !== 1'b0 || frame_count !== 8'd4) begin
      $display("FAIL ack_on_report fd=%b cp=%b fc=%0d expected 1/0/4", frame_done, coll_pf, frame_count);
      errors++;
    end
    tick();
    // Hit on the report cycle itself, coincident ack
    vsync_in = 1'b1; coll_ack = 1'b1;
    display_on = 1'b1; ball_gfx = 1'b1; pf_gfx = 1'b1; hpos = 9'd30; vpos = 9'd40;
    tick();
    idle_inputs();
    checks++;
    if (coll_pf !== 1'b1 || hit_hpos !== 9'd30 || hit_vpos !== 9'd40 || frame_count !== 8'd5) begin
      $display("FAIL hit_on_report cp=%b h=%0d v=%0d fc=%0d expected 1/30/40/5",
               coll_pf, hit_hpos, hit_vpos, frame_count);
      errors++;
    end
    tick();
  endtask

  task automatic test_pre_sync_ignored();
    do_reset();
    display_on = 1'b1; ball_gfx = 1'b1; pf_gfx = 1'b1; hpos = 9'd5; vpos = 9'd5;
    tick(); tick();
    idle_inputs();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || frame_count !== 8'd0) begin
      $display("FAIL pre_sync_edge fd=%b fc=%0d expected 0/0", frame_done, frame_count);
      errors++;
    end
    tick();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || coll_pf !== 1'b0 || frame_count !== 8'd1 ||
        hit_hpos !== 9'd0 || hit_vpos !== 9'd0) begin
      $display("FAIL pre_sync_report fd=%b cp=%b fc=%0d h=%0d v=%0d expected 1/0/1/0/0",
               frame_done, coll_pf, frame_count, hit_hpos, hit_vpos);
      errors++;
    end
    tick();
  endtask

  task automatic test_frame_wrap();
    do_reset();
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0; tick();
    for (int i = 0; i < 255; i++) begin
      vsync_in = 1'b1; tick();
      vsync_in = 1'b0; tick();
    end
    checks++;
    if (frame_count !== 8'd255) begin
      $display("FAIL count_255 fc=%0d expected 255", frame_count);
      errors++;
    end
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0; tick();
    checks++;
    if (frame_count !== 8'd0) begin
      $display("FAIL count_wrap fc=%0d expected 0", frame_count);
      errors++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_pixel_path();
    test_collision_report();
    test_border();
    test_ack_with_report();
    test_pre_sync_ignored();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
